// File: rtl/mem_stage.sv
// Memory-access stage: byte-serial loads/stores over a single 8-bit RAM port,
// ALU pass-through for other ops, and an upstream stall during multi-cycle accesses.
module mem_stage #(
    parameter int unsigned ADDR_W   = 32,
    parameter logic [6:0]  LOAD_OP  = 7'b0000011,
    parameter logic [6:0]  STORE_OP = 7'b0100011
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [6:0]        op_in,
    input  logic [2:0]        fun_in,
    input  logic [31:0]       res_in,
    input  logic [31:0]       imm_in,
    input  logic [4:0]        rd_in,
    input  logic              rec_in,
    input  logic              mem_gnt_in,
    input  logic [7:0]        mem_din_in,
    output logic [ADDR_W-1:0] mem_addr_out,
    output logic [7:0]        mem_dout_out,
    output logic              mem_wr_out,
    output logic              mem_req_out,
    output logic              stall_req_out,
    output logic [4:0]        rd_out,
    output logic [31:0]       wdata_out,
    output logic              we_out,
    output logic              rec_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [31:0]       data_q,  data_d;
    logic [2:0]        fun_q,   fun_d;
    logic [1:0]        last_q,  last_d;
    logic [1:0]        k_q,     k_d;
    logic              load_q,  load_d;
    logic [4:0]        rd_q,    rd_d;
    logic [31:0]       buf_q,   buf_d;
    logic              cap_v_q, cap_v_d;
    logic [1:0]        cap_k_q, cap_k_d;
    logic [4:0]        rdo_q,   rdo_d;
    logic [31:0]       wdo_q,   wdo_d;
    logic              weo_q,   weo_d;
    logic              reco_q,  reco_d;

    logic is_load, is_store, load_ok, store_ok;

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] r;
        case (lane)
            2'd0:    r = w[7:0];
            2'd1:    r = w[15:8];
            2'd2:    r = w[23:16];
            default: r = w[31:24];
        endcase
        return r;
    endfunction

    function automatic logic [1:0] last_index(input logic [1:0] sz);
        logic [1:0] r;
        case (sz)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] f);
        logic [31:0] r;
        case (f)
            3'b000:  r = {{24{w[7]}}, w[7:0]};
            3'b001:  r = {{16{w[15]}}, w[15:0]};
            3'b100:  r = {24'd0, w[7:0]};
            3'b101:  r = {16'd0, w[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

    assign is_load  = (op_in == LOAD_OP);
    assign is_store = (op_in == STORE_OP);
    assign load_ok  = fun_in inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign store_ok = fun_in inside {3'b000, 3'b001, 3'b010};

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        fun_d         = fun_q;
        last_d        = last_q;
        k_d           = k_q;
        load_d        = load_q;
        rd_d          = rd_q;
        buf_d         = buf_q;
        cap_v_d       = 1'b0;
        cap_k_d       = cap_k_q;
        rdo_d         = '0;
        wdo_d         = '0;
        weo_d         = 1'b0;
        reco_d        = 1'b0;
        mem_addr_out  = '0;
        mem_dout_out  = '0;
        mem_wr_out    = 1'b0;
        mem_req_out   = 1'b0;
        stall_req_out = 1'b0;

        // A byte issued under grant last cycle is on mem_din_in now, grant or not.
        if (cap_v_q) begin
            buf_d = put_byte(buf_q, cap_k_q, mem_din_in);
        end

        case (state_q)
            IDLE: begin
                if (rec_in) begin
                    if ((is_load && load_ok) || (is_store && store_ok)) begin
                        stall_req_out = 1'b1;
                        addr_d        = ADDR_W'(res_in);
                        data_d        = imm_in;
                        fun_d         = fun_in;
                        last_d        = last_index(fun_in[1:0]);
                        k_d           = 2'd0;
                        load_d        = is_load;
                        rd_d          = rd_in;
                        state_d       = BUSY;
                    end else if (is_load || is_store) begin
                        reco_d = 1'b1;
                    end else begin
                        rdo_d  = rd_in;
                        wdo_d  = res_in;
                        weo_d  = (rd_in != 5'd0);
                        reco_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                mem_req_out   = 1'b1;
                mem_addr_out  = addr_q + ADDR_W'(k_q);
                stall_req_out = 1'b1;
                if (!load_q) begin
                    mem_wr_out   = 1'b1;
                    mem_dout_out = get_byte(data_q, k_q);
                end
                if (mem_gnt_in) begin
                    cap_v_d = load_q;
                    cap_k_d = k_q;
                    if (k_q == last_q) begin
                        if (load_q) begin
                            state_d = WAIT;
                        end else begin
                            // Store completes on this edge; let upstream advance with it.
                            stall_req_out = 1'b0;
                            reco_d        = 1'b1;
                            state_d       = IDLE;
                        end
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            WAIT: begin
                wdo_d   = extend(buf_d, fun_q);
                rdo_d   = rd_q;
                weo_d   = (rd_q != 5'd0);
                reco_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst_in) begin
            stall_req_out = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            fun_q   <= '0;
            last_q  <= '0;
            k_q     <= '0;
            load_q  <= 1'b0;
            rd_q    <= '0;
            buf_q   <= '0;
            cap_v_q <= 1'b0;
            cap_k_q <= '0;
            rdo_q   <= '0;
            wdo_q   <= '0;
            weo_q   <= 1'b0;
            reco_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            fun_q   <= fun_d;
            last_q  <= last_d;
            k_q     <= k_d;
            load_q  <= load_d;
            rd_q    <= rd_d;
            buf_q   <= buf_d;
            cap_v_q <= cap_v_d;
            cap_k_q <= cap_k_d;
            rdo_q   <= rdo_d;
            wdo_q   <= wdo_d;
            weo_q   <= weo_d;
            reco_q  <= reco_d;
        end
    end

    assign rd_out    = rdo_q;
    assign wdata_out = wdo_q;
    assign we_out    = weo_q;
    assign rec_out   = reco_q;

endmodule
